// File: rtl/outputlogic_if.sv
// Bundles the data-bus, control, peek and display signals of the output logic block.
interface outputlogic_if;
  logic [9:0] databus;
  logic       Out_Enable;
  logic       PeeKb;
  logic [9:0] PeekData;
  logic [9:0] Result;
  logic       Valid;
  logic       NewResult;
  logic [9:0] LEDR;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [6:0] HEX2;
  logic [6:0] HEX3;

  modport master (
    output databus, Out_Enable, PeeKb, PeekData,
    input  Result, Valid, NewResult, LEDR, HEX0, HEX1, HEX2, HEX3
  );

  modport slave (
    input  databus, Out_Enable, PeeKb, PeekData,
    output Result, Valid, NewResult, LEDR, HEX0, HEX1, HEX2, HEX3
  );
endinterface

// File: rtl/outputlogic.sv
// Output logic: captures the data bus on a rising Out_Enable, blinks a "new result" LED,
// and drives LEDs plus four seven-segment digits (shown value or peeked register).
//
// state  | meaning
// IDLE   | nothing captured yet, digits show dashes
// SHOW   | digits show the latched Result
// PEEK   | peek key held, digits show PeekData with a 'P' on HEX3
module outputlogic #(
  parameter int unsigned BLINK_CYCLES = 25_000_000
) (
  input  logic     CLK_50MHz,
  input  logic     Reset,
  outputlogic_if.slave bus
);

  localparam logic [25:0] BLINK_LOAD = 26'(BLINK_CYCLES);

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_P     = 7'b0001100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SHOW = 2'd1,
    S_PEEK = 2'd2
  } state_t;

  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  state_t      state_q, state_d;
  logic        oe_q, oe_d;
  logic [9:0]  result_q, result_d;
  logic        valid_q, valid_d;
  logic [25:0] blink_q, blink_d;
  logic [6:0]  hex0_q, hex0_d;
  logic [6:0]  hex1_q, hex1_d;
  logic [6:0]  hex2_q, hex2_d;
  logic [6:0]  hex3_q, hex3_d;

  logic        capture;
  logic [9:0]  disp_val;

  assign capture  = bus.Out_Enable & ~oe_q;
  assign disp_val = (state_q == S_PEEK) ? bus.PeekData : result_q;

  // Capture path and blink timer
  always_comb begin
    oe_d     = bus.Out_Enable;
    result_d = result_q;
    valid_d  = valid_q;
    blink_d  = blink_q;
    if (capture) begin
      result_d = bus.databus;
      valid_d  = 1'b1;
      blink_d  = BLINK_LOAD;
    end else if (blink_q != 26'd0) begin
      blink_d = blink_q - 26'd1;
    end
  end

  // Display state transitions; a peek press wins over a capture for the next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.PeeKb)    state_d = S_PEEK;
        else if (capture) state_d = S_SHOW;
      end
      S_SHOW: begin
        if (bus.PeeKb) state_d = S_PEEK;
      end
      S_PEEK: begin
        if (!bus.PeeKb) state_d = valid_d ? S_SHOW : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Segment drives are registered from the current state and displayed value
  always_comb begin
    hex0_d = SEG_DASH;
    hex1_d = SEG_DASH;
    hex2_d = SEG_DASH;
    hex3_d = SEG_BLANK;
    if (state_q != S_IDLE) begin
      hex0_d = hex_seg(disp_val[3:0]);
      hex1_d = hex_seg(disp_val[7:4]);
      hex2_d = hex_seg({2'b00, disp_val[9:8]});
      hex3_d = (state_q == S_PEEK) ? SEG_P : SEG_BLANK;
    end
  end

  always_ff @(posedge CLK_50MHz) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      oe_q     <= 1'b0;
      result_q <= 10'd0;
      valid_q  <= 1'b0;
      blink_q  <= 26'd0;
      hex0_q   <= SEG_DASH;
      hex1_q   <= SEG_DASH;
      hex2_q   <= SEG_DASH;
      hex3_q   <= SEG_BLANK;
    end else begin
      state_q  <= state_d;
      oe_q     <= oe_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      blink_q  <= blink_d;
      hex0_q   <= hex0_d;
      hex1_q   <= hex1_d;
      hex2_q   <= hex2_d;
      hex3_q   <= hex3_d;
    end
  end

  assign bus.Result    = result_q;
  assign bus.LEDR      = result_q;
  assign bus.Valid     = valid_q;
  assign bus.NewResult = (blink_q != 26'd0);
  assign bus.HEX0      = hex0_q;
  assign bus.HEX1      = hex1_q;
  assign bus.HEX2      = hex2_q;
  assign bus.HEX3      = hex3_q;

endmodule

// File: tb/tb_outputlogic.sv
// Bench for outputlogic: directed stimulus, a cycle-level behavioural model checked
// every cycle, plus literal expectations for the documented scenarios.
module tb_outputlogic;
  localparam int BLINK = 4;

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  outputlogic_if bus_if ();

  outputlogic #(.BLINK_CYCLES(BLINK)) dut (
    .CLK_50MHz(clk),
    .Reset    (Reset),
    .bus      (bus_if)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg(input int n);
    case (n)
      0: return 7'b1000000;   1: return 7'b1111001;   2: return 7'b0100100;
      3: return 7'b0110000;   4: return 7'b0011001;   5: return 7'b0010010;
      6: return 7'b0000010;   7: return 7'b1111000;   8: return 7'b0000000;
      9: return 7'b0010000;  10: return 7'b0001000;  11: return 7'b0000011;
     12: return 7'b1000110;  13: return 7'b0100001;  14: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] PCHR  = 7'b0001100;

  // Model: mode 0 = idle, 1 = showing result, 2 = peeking
  int          m_mode;
  int          m_result;
  bit          m_valid;
  bit          m_prev_oe;
  bit          m_init = 1'b0;
  longint      m_cyc = 0;
  longint      m_last_cap = -1000;
  logic [6:0]  m_hex [4];

  initial forever begin
    @(posedge clk);
    m_cyc++;
    if (Reset) begin
      m_mode = 0; m_result = 0; m_valid = 0; m_prev_oe = 0;
      m_last_cap = -1000;
      m_hex[0] = DASH; m_hex[1] = DASH; m_hex[2] = DASH; m_hex[3] = BLANK;
      m_init = 1'b1;
    end else begin
      int v;
      bit cap;
      if (m_mode == 0) begin
        m_hex[0] = DASH; m_hex[1] = DASH; m_hex[2] = DASH; m_hex[3] = BLANK;
      end else begin
        v = (m_mode == 2) ? int'(bus_if.PeekData) : m_result;
        m_hex[0] = seg(v % 16);
        m_hex[1] = seg((v / 16) % 16);
        m_hex[2] = seg(v / 256);
        m_hex[3] = (m_mode == 2) ? PCHR : BLANK;
      end
      cap = bus_if.Out_Enable && !m_prev_oe;
      m_prev_oe = bus_if.Out_Enable;
      if (cap) begin
        m_result = int'(bus_if.databus);
        m_valid = 1;
        m_last_cap = m_cyc;
      end
      if (bus_if.PeeKb)      m_mode = 2;
      else if (m_mode == 2)  m_mode = m_valid ? 1 : 0;
      else if (cap)          m_mode = 1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_init) begin
      chk("model_result", 32'(bus_if.Result), 32'(m_result));
      chk("model_ledr",   32'(bus_if.LEDR), 32'(m_result));
      chk("model_valid",  32'(bus_if.Valid), 32'(m_valid));
      chk("model_newres", 32'(bus_if.NewResult), 32'((m_cyc - m_last_cap) < BLINK));
      chk("model_hex0",   32'(bus_if.HEX0), 32'(m_hex[0]));
      chk("model_hex1",   32'(bus_if.HEX1), 32'(m_hex[1]));
      chk("model_hex2",   32'(bus_if.HEX2), 32'(m_hex[2]));
      chk("model_hex3",   32'(bus_if.HEX3), 32'(m_hex[3]));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int nr_cnt;
    Reset = 1'b1;
    bus_if.Out_Enable = 1'b0;
    bus_if.PeeKb = 1'b0;
    bus_if.databus = 10'd0;
    bus_if.PeekData = 10'd0;

    cyc(2);
    chk("rst_result", 32'(bus_if.Result), 32'h0);
    chk("rst_valid", 32'(bus_if.Valid), 32'h0);
    chk("rst_newres", 32'(bus_if.NewResult), 32'h0);
    chk("rst_hex0", 32'(bus_if.HEX0), 32'(7'b0111111));
    chk("rst_hex2", 32'(bus_if.HEX2), 32'(7'b0111111));
    chk("rst_hex3", 32'(bus_if.HEX3), 32'(7'b1111111));
    Reset = 1'b0;
    cyc(1);

    // single capture
    bus_if.databus = 10'h2A7; bus_if.Out_Enable = 1'b1;
    cyc(1);
    bus_if.Out_Enable = 1'b0;
    chk("cap_result", 32'(bus_if.Result), 32'h2A7);
    chk("cap_ledr", 32'(bus_if.LEDR), 32'h2A7);
    chk("cap_valid", 32'(bus_if.Valid), 32'h1);
    nr_cnt = int'(bus_if.NewResult);
    cyc(1);
    chk("cap_hex0", 32'(bus_if.HEX0), 32'(7'b1111000));
    chk("cap_hex1", 32'(bus_if.HEX1), 32'(7'b0001000));
    chk("cap_hex2", 32'(bus_if.HEX2), 32'(7'b0100100));
    chk("cap_hex3", 32'(bus_if.HEX3), 32'(7'b1111111));
    nr_cnt += int'(bus_if.NewResult);
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      nr_cnt += int'(bus_if.NewResult);
    end
    chk("blink_len", 32'(nr_cnt), 32'd4);

    // held enable captures only the first value
    bus_if.Out_Enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus_if.databus = 10'(i * 37 + 1);
      cyc(1);
    end
    chk("held_result", 32'(bus_if.Result), 32'h001);
    bus_if.Out_Enable = 1'b0;
    cyc(1);
    bus_if.Out_Enable = 1'b1; bus_if.databus = 10'h3C3;
    cyc(1);
    bus_if.Out_Enable = 1'b0;
    cyc(1);
    bus_if.Out_Enable = 1'b1; bus_if.databus = 10'h0AB;
    cyc(1);
    bus_if.Out_Enable = 1'b0;
    chk("reload_result", 32'(bus_if.Result), 32'h0AB);
    nr_cnt = int'(bus_if.NewResult);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      nr_cnt += int'(bus_if.NewResult);
    end
    chk("reload_len", 32'(nr_cnt), 32'd4);

    // peek
    bus_if.PeekData = 10'h0F1; bus_if.PeeKb = 1'b1;
    cyc(2);
    chk("peek_hex0", 32'(bus_if.HEX0), 32'(7'b1111001));
    chk("peek_hex1", 32'(bus_if.HEX1), 32'(7'b0001110));
    chk("peek_hex2", 32'(bus_if.HEX2), 32'(7'b1000000));
    chk("peek_hex3", 32'(bus_if.HEX3), 32'(7'b0001100));
    bus_if.databus = 10'h155; bus_if.Out_Enable = 1'b1;
    cyc(1);
    bus_if.Out_Enable = 1'b0;
    chk("peekcap_result", 32'(bus_if.Result), 32'h155);
    cyc(1);
    chk("peekcap_hex0", 32'(bus_if.HEX0), 32'(7'b1111001));
    chk("peekcap_hex3", 32'(bus_if.HEX3), 32'(7'b0001100));
    bus_if.PeeKb = 1'b0;
    cyc(2);
    chk("rel_hex0", 32'(bus_if.HEX0), 32'(7'b0010010));
    chk("rel_hex1", 32'(bus_if.HEX1), 32'(7'b0010010));
    chk("rel_hex2", 32'(bus_if.HEX2), 32'(7'b1111001));
    chk("rel_hex3", 32'(bus_if.HEX3), 32'(7'b1111111));

    // peek before any result
    Reset = 1'b1;
    cyc(2);
    Reset = 1'b0;
    bus_if.PeeKb = 1'b1;
    cyc(1);
    bus_if.PeeKb = 1'b0;
    cyc(1);
    chk("early_peek_hex3", 32'(bus_if.HEX3), 32'(7'b0001100));
    cyc(1);
    chk("early_idle_hex0", 32'(bus_if.HEX0), 32'(7'b0111111));
    chk("early_idle_hex3", 32'(bus_if.HEX3), 32'(7'b1111111));
    chk("early_valid", 32'(bus_if.Valid), 32'h0);

    // capture and peek in the same cycle
    bus_if.databus = 10'h2F0; bus_if.Out_Enable = 1'b1; bus_if.PeeKb = 1'b1;
    cyc(1);
    bus_if.Out_Enable = 1'b0;
    chk("simul_result", 32'(bus_if.Result), 32'h2F0);
    cyc(1);
    chk("simul_hex3", 32'(bus_if.HEX3), 32'(7'b0001100));
    chk("simul_hex0", 32'(bus_if.HEX0), 32'(7'b1111001));
    bus_if.PeeKb = 1'b0;
    cyc(2);

    // reset mid-blink
    bus_if.databus = 10'h3FF; bus_if.Out_Enable = 1'b1;
    cyc(1);
    bus_if.Out_Enable = 1'b0;
    cyc(1);
    chk("midblink_newres", 32'(bus_if.NewResult), 32'h1);
    Reset = 1'b1;
    cyc(1);
    chk("midrst_newres", 32'(bus_if.NewResult), 32'h0);
    chk("midrst_result", 32'(bus_if.Result), 32'h0);
    chk("midrst_ledr", 32'(bus_if.LEDR), 32'h0);
    chk("midrst_hex1", 32'(bus_if.HEX1), 32'(7'b0111111));

    // Out_Enable already high when reset releases
    bus_if.Out_Enable = 1'b1;
    cyc(1);
    Reset = 1'b0; bus_if.databus = 10'h1A5;
    cyc(1);
    chk("rel_cap_result", 32'(bus_if.Result), 32'h1A5);
    chk("rel_cap_valid", 32'(bus_if.Valid), 32'h1);
    bus_if.Out_Enable = 1'b0;
    cyc(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
endmodule

// File: doc/outputlogic.md
# outputlogic

Output-side counterpart of the processor's input logic. Captures a result from the shared 10-bit data bus when the controller asserts `Out_Enable`, holds it, and presents it on the DE-10 Lite LEDs and four seven-segment displays. While the debounced peek key is held, it shows the register selected by the peek address instead. It flashes a "new result" LED for a fixed time after each capture.

## Interface
- `BLINK_CYCLES`, default 25_000_000: number of clock cycles `NewResult` stays high after a capture; legal range 1 to 2^26-1.
- `CLK_50MHz`  in  1  the 50 MHz board clock; all state changes on its rising edge.
- `Reset`  in  1  synchronous reset, active-high.
- `databus`  in  10  shared data bus; it is valid whenever `Out_Enable` is high.
- `Out_Enable`  in  1  level from the controller; its rising edge captures `databus`.
- `PeeKb`  in  1  debounced peek key, level, high = peek.
- `PeekData`  in  10  register-file read port driven by the peek address.
- `Result`  out  10  latched output value.
- `Valid`  out  1  high once at least one capture has occurred.
- `NewResult`  out  1  high for `BLINK_CYCLES` cycles after each capture.
- `LEDR`  out  10  copy of `Result`.
- `HEX0`, `HEX1`, `HEX2`, `HEX3`  out  7 each  segment drives, active-low, bit order gfedcba (bit 6 = g).

## Operation
- **Edge detect:** register `oe_q` holds the previous `Out_Enable` value.
  - A capture happens on a cycle where `Out_Enable` = 1 and `oe_q` = 0.
  - A level held high captures exactly once.
- **Capture:** loads `Result` with `databus`, sets `Valid` = 1, and loads the blink counter with `BLINK_CYCLES`.
- **Blink counter:** decrements by 1 per cycle while nonzero. `NewResult` = (counter != 0).
  - A capture while the counter is nonzero reloads it to `BLINK_CYCLES`; it never accumulates.
- **Display state machine:** states IDLE, SHOW, PEEK.
  - IDLE: `PeeKb` = 1 goes to PEEK; a capture goes to SHOW.
  - SHOW: `PeeKb` = 1 goes to PEEK.
  - PEEK: `PeeKb` = 0 goes to SHOW if `Valid`, otherwise to IDLE.
  - A capture in PEEK updates `Result` and `Valid`; the state stays PEEK.
  - Capture and peek press in the same cycle: capture is taken and the next state is PEEK.
- **Displayed value V:** `Result` in SHOW, `PeekData` in PEEK.
  - HEX0 = V[3:0] and HEX1 = V[7:4], as hex digits.
  - HEX2 = {2'b00, V[9:8]}.
  - HEX3 = letter P in PEEK, blank otherwise.
  - In IDLE, HEX0–HEX2 show a dash and HEX3 is blank.
- **Segment codes:**

  | Symbol | Code |
  |---|---|
  | 0 | 1000000 |
  | 1 | 1111001 |
  | 2 | 0100100 |
  | 3 | 0110000 |
  | 4 | 0011001 |
  | 5 | 0010010 |
  | 6 | 0000010 |
  | 7 | 1111000 |
  | 8 | 0000000 |
  | 9 | 0010000 |
  | A | 0001000 |
  | b | 0000011 |
  | C | 1000110 |
  | d | 0100001 |
  | E | 0000110 |
  | F | 0001110 |
  | dash | 0111111 |
  | blank | 1111111 |
  | P | 0001100 |

- **Bus:** `databus` is input-only here; the block never drives it.
- **Reset values:**
  - `Result` = 0, `Valid` = 0, `NewResult` = 0 (counter = 0), `LEDR` = 0.
  - `oe_q` = 0, state = IDLE.
  - HEX0–HEX2 = dash, HEX3 = blank.
- **Reset mid-operation:** overrides capture and peek in the same cycle and aborts any blink in progress.
- **`Out_Enable` high at reset release:** `oe_q` = 0, so the first clock after reset deasserts performs a capture.

## Timing
- Capture detected at edge k: `Result`, `Valid`, `LEDR`, state and counter update at edge k; `NewResult` is high from edge k.
- HEX outputs are registered from state and V, so they reflect a change at edge k+1.
- `NewResult` falls at edge k+`BLINK_CYCLES`, i.e. it is high for exactly `BLINK_CYCLES` cycles.
- `PeeKb` change sampled at edge k: state updates at edge k; HEX outputs at edge k+1.
- `PeekData` changes while in PEEK appear on HEX one edge after they are sampled.
- The block places no constraint on `Out_Enable` pulse width; a 1-cycle pulse is sufficient.
- Back-to-back pulses need at least one low cycle between them to be seen as two captures.

## Test plan
- **Reset:** assert `Reset` for 2 cycles with `Out_Enable` = 0 -> `Result` = 0, `Valid` = 0, `NewResult` = 0, HEX0–HEX2 = 0111111, HEX3 = 1111111.
- **Single capture:** `databus` = 10'h2A7, 1-cycle `Out_Enable` pulse, `BLINK_CYCLES` = 4 ->
  - `Result` = `LEDR` = 0x2A7 and `Valid` = 1 at that edge.
  - Next edge: HEX0 = 1111000 (7), HEX1 = 0001000 (A), HEX2 = 0100100 (2), HEX3 = blank.
  - `NewResult` high for exactly 4 cycles.
- **Held enable and reload:**
  - Hold `Out_Enable` high 10 cycles with `databus` changing every cycle -> only the first value is captured.
  - Drop `Out_Enable` for 1 cycle, then pulse again while `NewResult` = 1 -> `Result` updates and the blink counter restarts at 4.
- **Peek:**
  - `PeeKb` = 1 with `PeekData` = 10'h0F1 -> HEX shows 1, F, 0 and HEX3 = 0001100 (P).
  - Capture 10'h155 during peek -> HEX unchanged, `Result` = 0x155.
  - Release `PeeKb` -> HEX shows 5, 5, 1 with HEX3 blank.
- **Peek before any result:** `PeeKb` pulse after reset -> PEEK, then back to IDLE showing dashes; `Valid` stays 0.
- **Simultaneous and reset:**
  - Capture and `PeeKb` rise in the same cycle -> state PEEK and `Result` updated.
  - `Reset` mid-blink -> `NewResult` = 0 and all outputs at reset values next edge.
